// File: rtl/video_dsm_dac.sv
// Delta-sigma pin DAC for the composite video sample stream (1st or 2nd order).
// Optional +-1 LSB LFSR dither is compiled in when VIDEO_DSM_DITHER_EN is defined.
module video_dsm_dac #(
    parameter int C_IN_W  = 10,
    parameter int C_ORDER = 2,
    parameter int C_INT_W = 14
) (
    input  logic              CK_i,
    input  logic              XARST_i,
    input  logic              CK_EE_i,
    input  logic              RST_i,
    input  logic [C_IN_W-1:0] VIDEOs_i,
    output logic              VIDEO_o,
    output logic              OVF_o
);

    logic [C_IN_W-1:0] in_q;
    logic              video_q;
    logic              video_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              dith_p;
    logic              dith_n;

`ifdef VIDEO_DSM_DITHER_EN
    logic [14:0] lfsr_q;
    logic [14:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            lfsr_q <= 15'h0001;
        end else if (RST_i) begin
            lfsr_q <= 15'h0001;
        end else if (CK_EE_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dith_p = lfsr_q[0];
    assign dith_n = lfsr_q[1];
`else
    assign dith_p = 1'b0;
    assign dith_n = 1'b0;
`endif

    // Input stage and output/flag registers shared by both modulator orders
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            in_q    <= '0;
            video_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (RST_i) begin
            in_q    <= '0;
            video_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (CK_EE_i) begin
            in_q    <= VIDEOs_i;
            video_q <= video_d;
            ovf_q   <= ovf_d;
        end
    end

    assign VIDEO_o = video_q;
    assign OVF_o   = ovf_q;

    if (C_ORDER == 1) begin : g_ord1
        logic [C_IN_W-1:0] acc_q;
        logic [C_IN_W-1:0] acc_d;
        logic [C_IN_W:0]   sum;

        // Carry out of the phase accumulator is the pulse; dither can never exceed one carry
        always_comb begin
            sum     = {1'b0, acc_q} + {1'b0, in_q} + {{C_IN_W{1'b0}}, dith_p};
            acc_d   = sum[C_IN_W-1:0];
            video_d = sum[C_IN_W];
            ovf_d   = 1'b0;
        end

        always_ff @(posedge CK_i or negedge XARST_i) begin
            if (!XARST_i) begin
                acc_q <= '0;
            end else if (RST_i) begin
                acc_q <= '0;
            end else if (CK_EE_i) begin
                acc_q <= acc_d;
            end
        end
    end else if (C_ORDER == 2) begin : g_ord2
        localparam int W = C_INT_W + 2;
        localparam logic signed [W-1:0] SAT_MAX = $signed({3'b000, {(C_INT_W-1){1'b1}}});
        localparam logic signed [W-1:0] SAT_MIN = $signed({3'b111, {(C_INT_W-1){1'b0}}});

        logic signed [C_INT_W-1:0] i1_q;
        logic signed [C_INT_W-1:0] i1_d;
        logic signed [C_INT_W-1:0] i2_q;
        logic signed [C_INT_W-1:0] i2_d;
        logic signed [W-1:0]       x_w;
        logic signed [W-1:0]       fb_w;
        logic signed [W-1:0]       i1_sum;
        logic signed [W-1:0]       i2_sum;
        logic                      i1_hi;
        logic                      i1_lo;
        logic                      i2_hi;
        logic                      i2_lo;

        // Sums are two bits wider than the integrators so clamping sees the true value
        always_comb begin
            x_w    = $signed({{(W-C_IN_W){1'b0}}, in_q})
                   + $signed({{(W-1){1'b0}}, dith_p})
                   - $signed({{(W-1){1'b0}}, dith_n});
            fb_w   = video_q ? $signed({{(W-C_IN_W-1){1'b0}}, 1'b1, {C_IN_W{1'b0}}}) : '0;

            i1_sum = $signed({{2{i1_q[C_INT_W-1]}}, i1_q}) + x_w - fb_w;
            i1_hi  = i1_sum > SAT_MAX;
            i1_lo  = i1_sum < SAT_MIN;
            if (i1_hi) begin
                i1_d = SAT_MAX[C_INT_W-1:0];
            end else if (i1_lo) begin
                i1_d = SAT_MIN[C_INT_W-1:0];
            end else begin
                i1_d = i1_sum[C_INT_W-1:0];
            end

            i2_sum = $signed({{2{i2_q[C_INT_W-1]}}, i2_q})
                   + $signed({{2{i1_d[C_INT_W-1]}}, i1_d}) - fb_w;
            i2_hi  = i2_sum > SAT_MAX;
            i2_lo  = i2_sum < SAT_MIN;
            if (i2_hi) begin
                i2_d = SAT_MAX[C_INT_W-1:0];
            end else if (i2_lo) begin
                i2_d = SAT_MIN[C_INT_W-1:0];
            end else begin
                i2_d = i2_sum[C_INT_W-1:0];
            end

            video_d = !i2_d[C_INT_W-1] && (i2_d != '0);
            ovf_d   = ovf_q | i1_hi | i1_lo | i2_hi | i2_lo;
        end

        always_ff @(posedge CK_i or negedge XARST_i) begin
            if (!XARST_i) begin
                i1_q <= '0;
                i2_q <= '0;
            end else if (RST_i) begin
                i1_q <= '0;
                i2_q <= '0;
            end else if (CK_EE_i) begin
                i1_q <= i1_d;
                i2_q <= i2_d;
            end
        end
    end else begin : g_bad_order
        $error("video_dsm_dac: C_ORDER must be 1 or 2");
    end

endmodule

// File: tb/tb_video_dsm_dac.sv
// Scoreboard bench for video_dsm_dac: order-1, order-2 and narrow-integrator order-2 instances
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_video_dsm_dac;

    logic       ck = 1'b0;
    logic       xarst;
    logic       ck_ee;
    logic       rst;
    logic [9:0] vin;
    logic       v1, o1, v2, o2, vs, os;

    always #5 ck = ~ck;

    video_dsm_dac #(.C_IN_W(10), .C_ORDER(1), .C_INT_W(14)) u_ord1 (
        .CK_i(ck), .XARST_i(xarst), .CK_EE_i(ck_ee), .RST_i(rst),
        .VIDEOs_i(vin), .VIDEO_o(v1), .OVF_o(o1));

    video_dsm_dac #(.C_IN_W(10), .C_ORDER(2), .C_INT_W(14)) u_ord2 (
        .CK_i(ck), .XARST_i(xarst), .CK_EE_i(ck_ee), .RST_i(rst),
        .VIDEOs_i(vin), .VIDEO_o(v2), .OVF_o(o2));

    video_dsm_dac #(.C_IN_W(10), .C_ORDER(2), .C_INT_W(12)) u_sat (
        .CK_i(ck), .XARST_i(xarst), .CK_EE_i(ck_ee), .RST_i(rst),
        .VIDEOs_i(vin), .VIDEO_o(vs), .OVF_o(os));

    typedef struct {
        bit v1, o1, v2, o2, vs, os;
        bit clr, cnt, chk, ovz;
        int ovs;
        int lo1, hi1, lo2, hi2;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model state: index 0 = 14-bit integrators, 1 = 12-bit integrators
    int m_in  = 0;
    int m_acc = 0;
    bit m_v1  = 1'b0;
    int m_i1[2];
    int m_i2[2];
    bit m_v[2];
    bit m_ovf[2];

    bit g_clr = 1'b0, g_cnt = 1'b0, g_chk = 1'b0, g_ovz = 1'b0;
    int g_ovs = -1;
    int g_lo1 = 0, g_hi1 = 0, g_lo2 = 0, g_hi2 = 0;

    function automatic int clamp(input int a, input int w, output bit o);
        int mx = (1 << (w - 1)) - 1;
        int mn = -(1 << (w - 1));
        o = (a > mx) || (a < mn);
        if (a > mx) return mx;
        if (a < mn) return mn;
        return a;
    endfunction

    task automatic model_edge(input bit xa, input bit r, input bit ee, input int v);
        int s, fb, a, b, w;
        bit oa, ob;
        if (!xa || r) begin
            m_in = 0; m_acc = 0; m_v1 = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_i1[k] = 0; m_i2[k] = 0; m_v[k] = 1'b0; m_ovf[k] = 1'b0;
            end
        end else if (ee) begin
            s     = m_acc + m_in;
            m_v1  = (s >= 1024);
            m_acc = s % 1024;
            for (int k = 0; k < 2; k++) begin
                w       = (k == 0) ? 14 : 12;
                fb      = m_v[k] ? 1024 : 0;
                a       = m_i1[k] + m_in - fb;
                m_i1[k] = clamp(a, w, oa);
                b       = m_i2[k] + m_i1[k] - fb;
                m_i2[k] = clamp(b, w, ob);
                m_v[k]  = (m_i2[k] > 0);
                m_ovf[k] = m_ovf[k] | oa | ob;
            end
            m_in = v;
        end
    endtask

    task automatic step(input bit xa, input bit r, input bit ee, input int v);
        exp_t e;
        @(negedge ck);
        xarst = xa; rst = r; ck_ee = ee; vin = 10'(v);
        model_edge(xa, r, ee, v);
        e.v1 = m_v1;    e.o1 = 1'b0;
        e.v2 = m_v[0];  e.o2 = m_ovf[0];
        e.vs = m_v[1];  e.os = m_ovf[1];
        e.clr = g_clr;  e.cnt = g_cnt; e.chk = g_chk; e.ovz = g_ovz; e.ovs = g_ovs;
        e.lo1 = g_lo1;  e.hi1 = g_hi1; e.lo2 = g_lo2; e.hi2 = g_hi2;
        sb.push_back(e);
        g_clr = 1'b0; g_cnt = 1'b0; g_chk = 1'b0; g_ovz = 1'b0; g_ovs = -1;
    endtask

    // Sync reset (with enable low), then 1024 counted enabled output samples at constant v
    task automatic window(input int v, input bit toggle, input bit ovz);
        int n = 0;
        int p = 0;
        bit ee;
        g_clr = 1'b1;
        step(1'b1, 1'b1, 1'b0, v);
        step(1'b1, 1'b0, 1'b1, v);
        while (n < 1024) begin
            ee = toggle ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            p++;
            if (ee) begin
                n++;
                g_cnt = 1'b1;
                if (n == 1024) begin
                    g_chk = 1'b1;
                    g_lo1 = v; g_hi1 = v;
                    g_lo2 = (v < 2) ? 0 : v - 2;
                    g_hi2 = (v == 0) ? 0 : v + 2;
                    g_ovz = ovz;
                end
            end
            step(1'b1, 1'b0, ee, v);
        end
    endtask

    task automatic chk(input string nm, input logic act, input bit req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s @%0t: got %b, want %b", nm, $time, act, req);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0d, want %0d..%0d", nm, $time, act, lo, hi);
        end
    endtask

    // Monitor: one expected entry per clock edge, sampled 1 time unit after the edge
    initial begin
        exp_t e;
        int   c1 = 0;
        int   c2 = 0;
        forever begin
            @(posedge ck);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.clr) begin
                    c1 = 0; c2 = 0;
                end
                chk("ord1.video", v1, e.v1);
                chk("ord1.ovf",   o1, e.o1);
                chk("ord2.video", v2, e.v2);
                chk("ord2.ovf",   o2, e.o2);
                chk("sat.video",  vs, e.vs);
                chk("sat.ovf",    os, e.os);
                if (e.cnt) begin
                    c1 += int'(v1);
                    c2 += int'(v2);
                end
                if (e.chk) begin
                    chk_rng("ord1.density", c1, e.lo1, e.hi1);
                    chk_rng("ord2.density", c2, e.lo2, e.hi2);
                    if (e.ovz) chk("ord2.ovf_quiet", o2, 1'b0);
                end
                if (e.ovs >= 0) chk("sat.ovf_sticky", os, e.ovs[0]);
            end
        end
    end

    initial begin
        xarst = 1'b0; rst = 1'b0; ck_ee = 1'b1; vin = 10'd512;

        repeat (3) step(1'b0, 1'b0, 1'b1, 512);

        window(512, 1'b0, 1'b0);
        window(0, 1'b0, 1'b1);
        window(205, 1'b0, 1'b1);
        window(1023, 1'b0, 1'b0);

        // Saturation flag of the narrow instance must survive a quiet input until async reset
        repeat (63) step(1'b1, 1'b0, 1'b1, 0);
        g_ovs = 1;
        step(1'b1, 1'b0, 1'b1, 0);
        g_ovs = 0;
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b1, 0);

        window(300, 1'b1, 1'b1);

        step(1'b1, 1'b1, 1'b0, 700);
        repeat (40) step(1'b1, 1'b0, 1'b1, 700);
        step(1'b1, 1'b1, 1'b0, 700);
        repeat (40) step(1'b1, 1'b0, 1'b1, 700);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 1023)));
        end
        step(1'b1, 1'b0, 1'b1, 0);

        repeat (3) @(negedge ck);
        n_vec++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard.drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
